// File: rtl/mdu_hilo_pkg.sv
// Shared encodings for the multiply/divide unit: MDU op codes, FSM states,
// commit kinds and the datapath word width.
package mdu_hilo_pkg;

    localparam int WORD = 32;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    // How the pending 64-bit value is folded into {HI,LO} at commit.
    typedef enum logic [1:0] {
        K_SET  = 2'd0,
        K_ADD  = 2'd1,
        K_SUB  = 2'd2,
        K_KEEP = 2'd3
    } commit_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: maps op and operands to a {HI,LO}-shaped
// 64-bit result ({remainder, quotient} for divides) plus a divide-by-zero flag.
module mdu_arith
    import mdu_hilo_pkg::*;
(
    input  logic [3:0]        op,
    input  logic [WORD-1:0]   a,
    input  logic [WORD-1:0]   b,
    output logic [2*WORD-1:0] res,
    output logic              div_zero
);

    logic signed [2*WORD-1:0] sprod;
    logic [2*WORD-1:0]        uprod;
    logic [WORD-1:0]          b_safe;
    logic [WORD-1:0]          abs_a;
    logic [WORD-1:0]          abs_b;
    logic [WORD-1:0]          mag_q;
    logic [WORD-1:0]          mag_r;
    logic [WORD-1:0]          sq;
    logic [WORD-1:0]          sr;
    logic [WORD-1:0]          uq;
    logic [WORD-1:0]          ur;

    assign sprod = $signed({{WORD{a[WORD-1]}}, a}) * $signed({{WORD{b[WORD-1]}}, b});
    assign uprod = {{WORD{1'b0}}, a} * {{WORD{1'b0}}, b};

    // Divisor forced to 1 on zero so the dividers never see x; the result is discarded.
    assign b_safe = (b == '0) ? WORD'(1) : b;

    // Signed divide on magnitudes: truncates toward zero, remainder follows the
    // dividend, and 0x80000000 / -1 falls out as 0x80000000 r 0 without a special case.
    assign abs_a = a[WORD-1] ? (~a + WORD'(1)) : a;
    assign abs_b = b_safe[WORD-1] ? (~b_safe + WORD'(1)) : b_safe;
    assign mag_q = abs_a / abs_b;
    assign mag_r = abs_a % abs_b;
    assign sq    = (a[WORD-1] ^ b_safe[WORD-1]) ? (~mag_q + WORD'(1)) : mag_q;
    assign sr    = a[WORD-1] ? (~mag_r + WORD'(1)) : mag_r;
    assign uq    = a / b_safe;
    assign ur    = a % b_safe;

    always_comb begin
        res      = '0;
        div_zero = 1'b0;
        case (op)
            MDU_MULT, MDU_MADD, MDU_MSUB:    res = sprod;
            MDU_MULTU, MDU_MADDU, MDU_MSUBU: res = uprod;
            MDU_DIV: begin
                res      = {sr, sq};
                div_zero = (b == '0);
            end
            MDU_DIVU: begin
                res      = {ur, uq};
                div_zero = (b == '0);
            end
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [WORD-1:0] SrcA,
    input  logic [WORD-1:0] SrcB,
    input  logic [3:0]      MDUOp,
    input  logic            Start,
    input  logic            Cancel,
    output logic            Busy,
    output logic [WORD-1:0] HI,
    output logic [WORD-1:0] LO,
    output logic [WORD-1:0] MDURes,
    output state_e          dbg_state
);

    localparam int CW = 16;

    state_e            state;
    state_e            state_next;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_next;
    logic [2*WORD-1:0] hilo;
    logic [2*WORD-1:0] pend;
    commit_e           pend_kind;
    commit_e           launch_kind;
    logic              launch;
    logic              commit;
    logic              go;
    logic [2*WORD-1:0] arith_res;
    logic              div_zero;

    mdu_arith u_arith (
        .op       (MDUOp),
        .a        (SrcA),
        .b        (SrcB),
        .res      (arith_res),
        .div_zero (div_zero)
    );

    assign go = Start & ~Cancel;

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        launch      = 1'b0;
        commit      = 1'b0;
        launch_kind = K_SET;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    if (MDUOp == MDU_MULT || MDUOp == MDU_MULTU) begin
                        state_next = ST_MUL;
                        cnt_next   = CW'(MUL_CYCLES);
                        launch     = 1'b1;
                    end else if (MDUOp == MDU_DIV || MDUOp == MDU_DIVU) begin
                        state_next  = ST_DIV;
                        cnt_next    = CW'(DIV_CYCLES);
                        launch      = 1'b1;
                        launch_kind = div_zero ? K_KEEP : K_SET;
                    end
`ifdef MDU_MADD_EN
                    else if (MDUOp == MDU_MADD || MDUOp == MDU_MADDU) begin
                        state_next  = ST_MUL;
                        cnt_next    = CW'(MUL_CYCLES);
                        launch      = 1'b1;
                        launch_kind = K_ADD;
                    end else if (MDUOp == MDU_MSUB || MDUOp == MDU_MSUBU) begin
                        state_next  = ST_MUL;
                        cnt_next    = CW'(MUL_CYCLES);
                        launch      = 1'b1;
                        launch_kind = K_SUB;
                    end
`endif
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt == CW'(1)) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pend      <= '0;
            pend_kind <= K_SET;
            hilo      <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (launch) begin
                pend      <= arith_res;
                pend_kind <= launch_kind;
            end
            // Accumulates use HI/LO as they stand at commit, not at launch.
            if (commit) begin
                case (pend_kind)
                    K_SET:   hilo <= pend;
                    K_ADD:   hilo <= hilo + pend;
                    K_SUB:   hilo <= hilo - pend;
                    default: hilo <= hilo;
                endcase
            end else if (state == ST_IDLE && go && MDUOp == MDU_MTHI) begin
                hilo[2*WORD-1:WORD] <= SrcA;
            end else if (state == ST_IDLE && go && MDUOp == MDU_MTLO) begin
                hilo[WORD-1:0] <= SrcA;
            end
        end
    end

    assign Busy      = (state != ST_IDLE);
    assign HI        = hilo[2*WORD-1:WORD];
    assign LO        = hilo[WORD-1:0];
    assign dbg_state = state;

    always_comb begin
        MDURes = '0;
        if (MDUOp == MDU_MFHI)      MDURes = HI;
        else if (MDUOp == MDU_MFLO) MDURes = LO;
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed-vector bench for mdu_hilo: launches each op class, counts Busy
// cycles and checks HI/LO/MDURes against hand-computed values.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  MDUOp;
    logic        Start;
    logic        Cancel;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDURes;
    state_e      dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_hilo #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .MDUOp     (MDUOp),
        .Start     (Start),
        .Cancel    (Cancel),
        .Busy      (Busy),
        .HI        (HI),
        .LO        (LO),
        .MDURes    (MDURes),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Holds Start across exactly one rising edge; returns at the following negedge.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic cancel);
        @(negedge clk);
        MDUOp  = op;
        SrcA   = a;
        SrcB   = b;
        Start  = 1'b1;
        Cancel = cancel;
        @(negedge clk);
        Start  = 1'b0;
        Cancel = 1'b0;
        MDUOp  = MDU_NONE;
        SrcA   = $urandom;
        SrcB   = $urandom;
    endtask

    // Counts negedge samples with Busy high, starting at the current negedge.
    task automatic busy_len(output int n);
        n = 0;
        while (Busy && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0; SrcA = '0; SrcB = '0; MDUOp = MDU_NONE; Start = 1'b0; Cancel = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, Busy}, 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        rst_n = 1'b1;

        launch(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        busy_len(n);
        check("mult_busy", n, 32'd5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFA);

        launch(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
        busy_len(n);
        check("multu_busy", n, 32'd5);
        check("multu_hi", HI, 32'h0000_0002);
        check("multu_lo", LO, 32'hFFFF_FFFA);

        launch(MDU_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0);
        busy_len(n);
        check("mult_min_hi", HI, 32'h4000_0000);
        check("mult_min_lo", LO, 32'h0000_0000);

        launch(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
        busy_len(n);
        check("div_busy", n, 32'd10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        launch(MDU_DIVU, 32'd7, 32'd2, 1'b0);
        busy_len(n);
        check("divu_lo", LO, 32'd3);
        check("divu_hi", HI, 32'd1);

        launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        busy_len(n);
        check("div_ovf_lo", LO, 32'h8000_0000);
        check("div_ovf_hi", HI, 32'h0000_0000);

        launch(MDU_MTHI, 32'h11, 32'd0, 1'b0);
        check("mthi_no_busy", {31'b0, Busy}, 32'd0);
        launch(MDU_MTLO, 32'h22, 32'd0, 1'b0);
        launch(MDU_DIV, 32'd1234, 32'd0, 1'b0);
        busy_len(n);
        check("div0_busy", n, 32'd10);
        check("div0_hi", HI, 32'h11);
        check("div0_lo", LO, 32'h22);

        launch(MDU_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check("mthi_busy", {31'b0, Busy}, 32'd0);
        check("mthi_hi", HI, 32'hDEAD_BEEF);
        MDUOp = MDU_MFHI;
        #1 check("mfhi_res", MDURes, 32'hDEAD_BEEF);
        MDUOp = MDU_MFLO;
        #1 check("mflo_res", MDURes, 32'h22);
        MDUOp = MDU_NONE;
        #1 check("none_res", MDURes, 32'd0);

        launch(MDU_MTLO, 32'h55, 32'd0, 1'b1);
        check("mtlo_cancel_lo", LO, 32'h22);

        launch(MDU_MULT, 32'd9, 32'd9, 1'b1);
        check("mult_cancel_busy", {31'b0, Busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("mult_cancel_lo", LO, 32'h22);

        // Second Start two cycles into a divide must not restart or redirect it.
        launch(MDU_DIV, 32'd100, 32'd7, 1'b0);
        check("div_restart_busy1", {31'b0, Busy}, 32'd1);
        launch(MDU_MULT, 32'd5, 32'd5, 1'b0);
        busy_len(n);
        check("div_restart_rest", n, 32'd8);
        check("div_restart_lo", LO, 32'd14);
        check("div_restart_hi", HI, 32'd2);

        launch(MDU_MULT, 32'd3, 32'd4, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'b0, Busy}, 32'd0);
        check("async_rst_hi", HI, 32'd0);
        check("async_rst_lo", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("rst_abort_lo", LO, 32'd0);
        check("rst_abort_busy", {31'b0, Busy}, 32'd0);

`ifdef MDU_MADD_EN
        launch(MDU_MTLO, 32'd1, 32'd0, 1'b0);
        launch(MDU_MADD, 32'd2, 32'd3, 1'b0);
        busy_len(n);
        check("madd_busy", n, 32'd5);
        check("madd_lo", LO, 32'd7);
        check("madd_hi", HI, 32'd0);
        launch(MDU_MTLO, 32'd1, 32'd0, 1'b0);
        launch(MDU_MSUBU, 32'd1, 32'd2, 1'b0);
        busy_len(n);
        check("msubu_hi", HI, 32'hFFFF_FFFF);
        check("msubu_lo", LO, 32'hFFFF_FFFF);
`else
        launch(MDU_MTLO, 32'd1, 32'd0, 1'b0);
        launch(MDU_MADD, 32'd2, 32'd3, 1'b0);
        check("madd_off_busy", {31'b0, Busy}, 32'd0);
        repeat (6) @(negedge clk);
        check("madd_off_lo", LO, 32'd1);
        check("madd_off_hi", HI, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the 32-bit ALU and takes the same SrcA/SrcB operands from the ID/EX register.
- Executes MULT/MULTU/DIV/DIVU and MTHI/MTLO, and returns HI/LO for MFHI/MFLO.
- Reports Busy so the hazard unit can stall later MDU instructions.

Parameters:
- MUL_CYCLES, 5: cycles Busy stays high for a multiply (>=1).
- DIV_CYCLES, 10: cycles Busy stays high for a divide (>=1).

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- SrcA, in, 32: operand rs.
- SrcB, in, 32: operand rt.
- MDUOp, in, 4: operation code, encodings `MDU_* in macro.vh.
- Start, in, 1: launch the MDUOp in this cycle; valid for MULT/MULTU/DIV/DIVU/MTHI/MTLO (and MADD family).
- Cancel, in, 1: the instruction in EX is being flushed (exception/interrupt); suppresses launch and writes.
- Busy, out, 1: an arithmetic operation is in flight.
- HI, out, 32: architectural HI register.
- LO, out, 32: architectural LO register.
- MDURes, out, 32: HI when MDUOp==`MDU_MFHI, LO when `MDU_MFLO, else 0 (combinational).

Behaviour:
- Reset (rst_n low, asynchronous): HI=0, LO=0, Busy=0, state=IDLE, counter=0, pending result=0. A reset mid-operation aborts it; HI/LO do not receive that result.
- FSM states:
  - IDLE -> MUL on Start & ~Cancel & MDUOp in {MULT, MULTU}.
  - IDLE -> DIV on Start & ~Cancel & MDUOp in {DIV, DIVU}.
  - MUL/DIV -> IDLE when the counter reaches 1; HI/LO are committed on that edge.
- Launch edge: operands are sampled and the 64-bit result is latched into a pending register. The counter loads MUL_CYCLES or DIV_CYCLES.
- Timing: with Start sampled at edge k, Busy is high for exactly N cycles after edge k. New HI/LO are visible and Busy is low from edge k+N.
- Busy = (state != IDLE), registered.
- The hazard unit stalls any MDU-class instruction in ID while (Start & EX is MDU-arith) | Busy.
- Start while Busy is ignored; operands change nothing in flight.
- MTHI/MTLO while IDLE with Start & ~Cancel: HI or LO takes SrcA at that edge, with no Busy. While Busy they are ignored (the hazard unit guarantees they do not occur).
- Cancel with Start: nothing is launched or written. Cancel while Busy has no effect; an op already launched completes.
- MULT: {HI,LO} = signed 32x32 -> 64. MULTU: unsigned.
- DIV (signed):
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero: takes the full DIV_CYCLES, then HI/LO stay unchanged. No exception is raised.
- MDURes reads the current registers. An MF during Busy is prevented by a stall, so there is no forwarding of pending results.
- No exceptions are generated by this block.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - Adds `MDU_MADD, `MDU_MADDU, `MDU_MSUB, `MDU_MSUBU, which take MUL_CYCLES.
  - Commit computes {HI,LO} ± product modulo 2^64, using the HI/LO value at commit time.
  - Products are signed for MADD/MSUB and unsigned for MADDU/MSUBU.
- Undefined: these codes are treated as no-op. Start is ignored, and Busy and HI/LO are unchanged.

Decomposition:
- macro.vh gets `MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
- State encodings and the `Word width also live in macro.vh.
- One sub-module: mdu_arith, purely combinational. It maps op and operands to a 64-bit result and a div-by-zero flag.
- mdu_hilo holds the FSM, counter, pending register and HI/LO.

Test Plan:
- Reset then MULT A=0xFFFFFFFE(-2), B=3 -> Busy high 5 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFFA; Busy low at edge 5.
- MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=-7, B=2 -> Busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 7/2 -> LO=3, HI=1.
- DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIV by 0 with HI=0x11, LO=0x22 -> Busy 10 cycles, then HI=0x11, LO=0x22.
- MTHI 0xDEADBEEF, then MDUOp=MFHI -> HI updates the next edge with no Busy; MDURes=0xDEADBEEF.
- Start of MTLO with Cancel=1 -> LO unchanged.
- Start MULT with Cancel=1 -> Busy stays 0.
- Start DIV, second Start MULT at cycle 3 -> ignored; DIV result is committed at cycle 10.
- rst_n low at cycle 4 of a MULT -> Busy=0, HI=LO=0 immediately (async).
- (MDU_MADD_EN) HI:LO=0:1, MADD 2,3 -> LO=7.
- (MDU_MADD_EN) HI:LO=0:1, MSUBU 1,2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFF.
